// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control path: states, instruction fields,
// write-back selects, and the instruction-class enumeration.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    localparam logic [3:0] OP_MEM    = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_LOAD  = 3'd1,
        CLS_STOR  = 3'd2,
        CLS_JAL   = 3'd3,
        CLS_JCOND = 3'd4,
        CLS_BCOND = 3'd5,
        CLS_NOP   = 3'd6
    } instr_class_t;

    // Per-cycle control strobes driven by the sequencer.
    typedef struct packed {
        logic       mem_en_a;
        logic       ir_en;
        logic       pc_en;
        logic       pc_load;
        logic       reg_wr_en;
        logic       flags_en;
        logic       mar_en;
        logic       mdr_en;
        logic       mem_we_b;
        logic [1:0] wb_sel;
    } ctrl_t;

endpackage

// File: rtl/instr_classify.sv
// Combinational instruction classifier: opcode [15:12] and ext [7:4]
// select one instruction class.
module instr_classify
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output logic [2:0]  cls
);

    logic [3:0]   opcode;
    logic [3:0]   ext;
    instr_class_t c;
    logic         unused_bits;

    assign opcode      = instr[15:12];
    assign ext         = instr[7:4];
    assign unused_bits = ^{instr[11:8], instr[3:0]};

    always_comb begin
        c = CLS_ALU;
        if (opcode == OP_BCOND) begin
            c = CLS_BCOND;
        end else if (opcode == OP_MEM) begin
            case (ext)
                EXT_LOAD:  c = CLS_LOAD;
                EXT_STOR:  c = CLS_STOR;
                EXT_JAL:   c = CLS_JAL;
                EXT_JCOND: c = CLS_JCOND;
                default:   c = CLS_NOP;
            endcase
        end
    end

    assign cls = c;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC with optional MEM and
// WB stages; strobes are decoded combinationally from state and instruction.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        cond_true,
    output logic        mem_en_a,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_load,
    output logic        reg_wr_en,
    output logic        flags_en,
    output logic        mar_en,
    output logic        mdr_en,
    output logic        mem_we_b,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state
);

    state_t       state_q;
    state_t       state_d;
    ctrl_t        ctrl;
    logic [2:0]   cls_raw;
    instr_class_t cls;

    instr_classify u_classify (
        .instr (instr),
        .cls   (cls_raw)
    );

    assign cls = instr_class_t'(cls_raw);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // The last stage of every instruction is the only place run is sampled.
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ctrl.mem_en_a = 1'b1;
                state_d       = ST_DECODE;
            end
            ST_DECODE: begin
                ctrl.ir_en = 1'b1;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = run ? ST_FETCH : ST_IDLE;
                case (cls)
                    CLS_ALU: begin
                        ctrl.reg_wr_en = 1'b1;
                        ctrl.flags_en  = 1'b1;
                        ctrl.pc_en     = 1'b1;
                        ctrl.wb_sel    = WB_ALU;
                    end
                    CLS_LOAD: begin
                        ctrl.mar_en = 1'b1;
                        state_d     = ST_MEM;
                    end
                    CLS_STOR: begin
                        ctrl.mar_en = 1'b1;
                        ctrl.mdr_en = 1'b1;
                        state_d     = ST_MEM;
                    end
                    CLS_JAL: begin
                        ctrl.reg_wr_en = 1'b1;
                        ctrl.wb_sel    = WB_PC;
                        ctrl.pc_load   = 1'b1;
                    end
                    CLS_JCOND, CLS_BCOND: begin
                        ctrl.pc_load = cond_true;
                        ctrl.pc_en   = ~cond_true;
                    end
                    default: begin
                        ctrl.pc_en = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                if (cls == CLS_STOR) begin
                    ctrl.mem_we_b = 1'b1;
                    ctrl.pc_en    = 1'b1;
                    state_d       = run ? ST_FETCH : ST_IDLE;
                end else begin
                    // LOAD: synchronous read data arrives next cycle
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                ctrl.reg_wr_en = 1'b1;
                ctrl.wb_sel    = WB_MEM;
                ctrl.pc_en     = 1'b1;
                state_d        = run ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_en_a  = ctrl.mem_en_a;
    assign ir_en     = ctrl.ir_en;
    assign pc_en     = ctrl.pc_en;
    assign pc_load   = ctrl.pc_load;
    assign reg_wr_en = ctrl.reg_wr_en;
    assign flags_en  = ctrl.flags_en;
    assign mar_en    = ctrl.mar_en;
    assign mdr_en    = ctrl.mdr_en;
    assign mem_we_b  = ctrl.mem_we_b;
    assign wb_sel    = ctrl.wb_sel;
    assign state     = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model pushes the
// expected per-cycle state/strobe vector; a negedge monitor pops and compares.
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] instr;
    logic        cond_true;
    logic        mem_en_a, ir_en, pc_en, pc_load, reg_wr_en, flags_en;
    logic        mar_en, mdr_en, mem_we_b;
    logic [1:0]  wb_sel;
    logic [2:0]  state;

    cpu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .instr     (instr),
        .cond_true (cond_true),
        .mem_en_a  (mem_en_a),
        .ir_en     (ir_en),
        .pc_en     (pc_en),
        .pc_load   (pc_load),
        .reg_wr_en (reg_wr_en),
        .flags_en  (flags_en),
        .mar_en    (mar_en),
        .mdr_en    (mdr_en),
        .mem_we_b  (mem_we_b),
        .wb_sel    (wb_sel),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_ALU = 0, K_LOAD = 1, K_STOR = 2, K_JAL = 3;
    localparam int K_JCOND = 4, K_BCOND = 5, K_NOP = 6;

    int n_chk  = 0;
    int n_fail = 0;

    logic [13:0] exp_q[$];

    // Instruction-level reference: idle, or busy at a stage index within the instruction.
    bit m_busy  = 0;
    int m_phase = 0;

    logic [13:0] act_vec;
    assign act_vec = {state, mem_en_a, ir_en, pc_en, pc_load, reg_wr_en,
                      flags_en, mar_en, mdr_en, mem_we_b, wb_sel};

    function automatic int ins_cls(input logic [15:0] ins);
        logic [3:0] op, ex;
        op = ins[15:12];
        ex = ins[7:4];
        if (op == 4'hC) return K_BCOND;
        if (op != 4'h4) return K_ALU;
        if (ex == 4'h0) return K_LOAD;
        if (ex == 4'h4) return K_STOR;
        if (ex == 4'h8) return K_JAL;
        if (ex == 4'hC) return K_JCOND;
        return K_NOP;
    endfunction

    function automatic int ins_len(input logic [15:0] ins);
        int k;
        k = ins_cls(ins);
        if (k == K_LOAD) return 5;
        if (k == K_STOR) return 4;
        return 3;
    endfunction

    function automatic logic [13:0] model_out(input bit busy, input int ph,
                                              input logic [15:0] ins, input bit c);
        logic [2:0] st;
        logic m, i, pe, pl, rw, fe, ma, md, we;
        logic [1:0] wb;
        int k;
        st = 3'd0; {m, i, pe, pl, rw, fe, ma, md, we} = '0; wb = 2'b00;
        k = ins_cls(ins);
        if (busy) begin
            st = 3'(ph + 1);
            case (ph)
                0: m = 1;
                1: i = 1;
                2: begin
                    if (k == K_ALU) begin rw = 1; fe = 1; pe = 1; end
                    else if (k == K_LOAD) ma = 1;
                    else if (k == K_STOR) begin ma = 1; md = 1; end
                    else if (k == K_JAL) begin rw = 1; wb = 2'b10; pl = 1; end
                    else if (k == K_JCOND || k == K_BCOND) begin pl = c; pe = !c; end
                    else pe = 1;
                end
                3: if (k == K_STOR) begin we = 1; pe = 1; end
                4: begin rw = 1; wb = 2'b01; pe = 1; end
                default: ;
            endcase
        end
        return {st, m, i, pe, pl, rw, fe, ma, md, we, wb};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, push the expectation, advance the model.
    task automatic cycle(input bit r, input bit c, input logic [15:0] ins, input bit rs);
        @(posedge clk);
        #1;
        reset = rs; run = r; cond_true = c; instr = ins;
        if (rs) begin
            exp_q.push_back(14'd0);
            m_busy = 0;
            #1 check("reset_immediate", act_vec, 14'd0);
        end else begin
            exp_q.push_back(model_out(m_busy, m_phase, ins, c));
            if (!m_busy) begin
                if (r) begin m_busy = 1; m_phase = 0; end
            end else begin
                m_phase++;
                if (m_phase == ins_len(ins)) begin
                    if (r) m_phase = 0;
                    else   m_busy  = 0;
                end
            end
        end
    endtask

    // Runs one instruction from its FETCH stage; mid_mode 0: run=1, 1: random, 2: run_last from DECODE on.
    task automatic exec_instr(input logic [15:0] ins, input bit c, input bit run_last, input int mid_mode);
        int n;
        n = ins_len(ins);
        for (int p = 0; p < n; p++) begin
            bit r, cc;
            if (p == n - 1)                 r = run_last;
            else if (mid_mode == 1)         r = bit'($urandom % 2);
            else if (mid_mode == 2 && p >= 1) r = run_last;
            else                            r = 1'b1;
            cc = (p == 2) ? c : bit'($urandom % 2);
            cycle(r, cc, ins, 1'b0);
        end
    endtask

    task automatic start(input logic [15:0] ins, input int idles);
        for (int j = 0; j < idles; j++) cycle(1'b0, bit'($urandom % 2), 16'($urandom), 1'b0);
        cycle(1'b1, bit'($urandom % 2), ins, 1'b0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        int sel;
        w   = 16'($urandom);
        sel = int'($urandom % 7);
        case (sel)
            0: if (w[15:12] == 4'h4 || w[15:12] == 4'hC) w[15:12] = 4'h0;
            1: begin w[15:12] = 4'h4; w[7:4] = 4'h0; end
            2: begin w[15:12] = 4'h4; w[7:4] = 4'h4; end
            3: begin w[15:12] = 4'h4; w[7:4] = 4'h8; end
            4: begin w[15:12] = 4'h4; w[7:4] = 4'hC; end
            5: w[15:12] = 4'hC;
            default: begin
                w[15:12] = 4'h4;
                if (w[5:4] == 2'b00) w[4] = 1'b1;
            end
        endcase
        return w;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            e = exp_q.pop_front();
            check("ctrl_vec", act_vec, e);
            n_chk++;
            if (pc_en && pc_load) begin
                n_fail++;
                $display("FAIL pc_exclusive at %0t: pc_en=%b pc_load=%b required not both 1",
                         $time, pc_en, pc_load);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0; instr = 16'h0; cond_true = 1'b0;
        #2 check("reset_state", act_vec, 14'd0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        // Release with run=1: FETCH on the very next edge.
        cycle(1'b1, 1'b0, 16'h0152, 1'b0);
        exec_instr(16'h0152, 1'b0, 1'b1, 0);
        exec_instr(16'h4102, 1'b0, 1'b1, 0);
        exec_instr(16'h4142, 1'b0, 1'b1, 0);
        exec_instr(16'hC0F3, 1'b1, 1'b1, 0);
        exec_instr(16'hC0F3, 1'b0, 1'b1, 0);
        // LOAD abandoned by reset during MEM.
        cycle(1'b1, 1'b0, 16'h4102, 1'b0);
        cycle(1'b1, 1'b0, 16'h4102, 1'b0);
        cycle(1'b1, 1'b0, 16'h4102, 1'b0);
        cycle(1'b1, 1'b0, 16'h4102, 1'b1);
        cycle(1'b1, 1'b0, 16'h4102, 1'b1);
        cycle(1'b0, 1'b0, 16'h4102, 1'b0);
        cycle(1'b0, 1'b0, 16'h4102, 1'b0);
        start(16'h0152, 0);
        // Run dropped at DECODE: finishes the instruction, then stays idle.
        exec_instr(16'h0152, 1'b0, 1'b0, 2);
        start(16'h4142, 3);
        exec_instr(16'h4142, 1'b1, 1'b1, 0);
        for (int t = 0; t < 150; t++) begin
            logic [15:0] ins;
            ins = rand_instr();
            if (!m_busy) start(ins, int'($urandom % 3));
            exec_instr(ins, bit'($urandom % 2), ($urandom % 5) != 0, 1);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-003 run  input  1  1 = execute instructions; 0 = stop at the next instruction boundary.
REQ-004 instr  input  16  current instruction word from memory port A read data; [15:12] opcode, [7:4] ext.
REQ-005 cond_true  input  1  branch condition result, evaluated externally from flags and instr[11:8].
REQ-006 mem_en_a  output  1  port A read strobe for the instruction fetch.
REQ-007 ir_en  output  1  instruction register load.
REQ-008 pc_en  output  1  PC load with PC+1.
REQ-009 pc_load  output  1  PC load with the branch/jump target; never asserted together with pc_en.
REQ-010 reg_wr_en  output  1  register file write of Rdest.
REQ-011 flags_en  output  1  flag register update.
REQ-012 mar_en, mdr_en  output  1 each  memory address and data register loads.
REQ-013 mem_we_b  output  1  port B write strobe.
REQ-014 wb_sel  output  2  write-back source: 00 ALU, 01 memory, 10 PC+1.
REQ-015 state  output  3  current state encoding, for debug.

Function
REQ-016 Instruction classes:
 - ALU: opcode != 0100 and != 1100.
 - LOAD: opcode 0100, ext 0000.
 - STOR: opcode 0100, ext 0100.
 - JAL: opcode 0100, ext 1000.
 - JCOND: opcode 0100, ext 1100.
 - BCOND: opcode 1100.
 - NOP: any other opcode-0100 ext.
REQ-017 States and transitions:
 - IDLE: -> FETCH when run=1.
 - FETCH: -> DECODE.
 - DECODE: -> EXEC.
 - EXEC: -> MEM for LOAD and STOR; otherwise -> FETCH if run=1, else IDLE.
 - MEM: -> WB for LOAD; for STOR -> FETCH if run=1, else IDLE.
 - WB: -> FETCH if run=1, else IDLE.
REQ-018 Outputs are combinational from state and instr. Every output is 0 unless listed for the current state.
REQ-019 FETCH asserts mem_en_a.
REQ-020 DECODE asserts ir_en.
REQ-021 EXEC, by class:
 - ALU: reg_wr_en, flags_en, pc_en, wb_sel=00.
 - LOAD: mar_en.
 - STOR: mar_en, mdr_en.
 - JAL: reg_wr_en, wb_sel=10, pc_load.
 - JCOND/BCOND: pc_load if cond_true=1, else pc_en.
 - NOP: pc_en.
REQ-022 MEM: STOR asserts mem_we_b and pc_en; LOAD asserts no outputs (one-cycle synchronous read wait).
REQ-023 WB (LOAD only) asserts reg_wr_en, wb_sel=01 and pc_en.
REQ-024 Latency from FETCH entry to the next FETCH entry:
 - ALU, NOP, JAL, JCOND, BCOND: 3 cycles.
 - STOR: 4 cycles.
 - LOAD: 5 cycles.
REQ-025 run is sampled only at instruction boundaries; deasserting run mid-instruction completes the current instruction, then enters IDLE.
REQ-026 cond_true is sampled only in EXEC; changes in other states have no effect.
REQ-027 Exactly one of pc_en or pc_load pulses, for exactly one cycle, per executed instruction.

Reset
REQ-028 reset=1 forces state=IDLE and all outputs to 0 (wb_sel=00, state=000), including mid-instruction; the partially executed instruction is abandoned with no further strobes.
REQ-029 After reset deasserts, the first FETCH occurs on the first clk edge with run=1.

Structure
REQ-030 Shared package cpu_ctrl_pkg holds:
 - state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5;
 - opcode and ext constants;
 - wb_sel encodings;
 - the instruction-class enumeration.
REQ-031 One combinational sub-module, instr_classify, maps instr to class; cpu_sequencer instantiates it once.

Verification
REQ-032 reset, then run=1 with instr=0x0152 (ALU ADD) -> states IDLE,FETCH,DECODE,EXEC,FETCH; EXEC has reg_wr_en=flags_en=pc_en=1, wb_sel=00.
REQ-033 instr=0x4102 (LOAD) -> EXEC mar_en=1; MEM all 0; WB reg_wr_en=1, wb_sel=01, pc_en=1; 5 cycles.
REQ-034 instr=0x4142 (STOR) -> EXEC mar_en=mdr_en=1; MEM mem_we_b=1, pc_en=1; 4 cycles.
REQ-035 instr=0xC0F3 (BCOND):
 - cond_true=1 in EXEC -> pc_load=1, pc_en=0;
 - repeated with cond_true=0 -> pc_en=1, pc_load=0.
REQ-036 LOAD in progress, reset pulsed during MEM -> outputs 0 immediately, state=IDLE, no WB strobe follows.
REQ-037 run dropped during DECODE of 0x0152 -> EXEC completes with pc_en=1, then IDLE; no further mem_en_a until run=1.
